regfile_mp_sb: RTL and testbench



---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_bypass_mux.sv | 51 +++++
 rtl/regfile_mp_sb.sv | 103 ++++++++++
 tb/tb_regfile_mp_sb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  // Ceiling log2, usable in constant expressions for address widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// One read port: priority-matches the read address against the write ports,
// chooses forwarded or stored data and qualifies the busy bit.
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int AW     = 5,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]       raddr,
  input  logic                raddr_ok,
  input  logic [XLEN-1:0]     rd_stored,
  input  logic                busy_stored,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  output logic [XLEN-1:0]     rdata,
  output logic                rbusy
);

  logic            hit;
  logic [XLEN-1:0] fwd_data;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    hit      = 1'b0;
    fwd_data = '0;
    // Ascending scan: the last (highest-index) matching port overrides earlier ones.
    for (int w = 0; w < NWR; w++) begin
      if (we[w] && (waddr[w*AW +: AW] == raddr)) begin
        hit      = 1'b1;
        fwd_data = wdata[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata = rd_stored;
    rbusy = busy_stored;
    if (!raddr_ok || (raddr == AW'(ZERO_REG))) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if ((BYPASS != 0) && hit) begin
      rdata = fwd_data;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hardwired-zero x0, optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (clog2(NREGS) < 1) ? 1 : clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd
);

  localparam int AWP = AW + 1;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic [AW-1:0] waddr_a [NWR];
  logic          wr_ok   [NWR];

  // Addresses beyond NREGS exist only when NREGS is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < AWP'(NREGS);
  endfunction

  for (genvar w = 0; w < NWR; w++) begin : g_wr
    assign waddr_a[w] = waddr[w*AW +: AW];
    assign wr_ok[w]   = we[w] && (waddr_a[w] != AW'(ZERO_REG)) && in_range(waddr_a[w]);
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // NOTE: next-state logic uses blocking '=' so later ports override earlier
    // ones within this evaluation; the flops below use non-blocking '<='.
    for (int w = 0; w < NWR; w++) begin
      if (wr_ok[w]) begin
        regs_d[waddr_a[w]] = wdata[w*XLEN +: XLEN];
        busy_d[waddr_a[w]] = 1'b0;
      end
    end
    // Applied after the clears so a new producer supersedes a completing one.
    if (issue_valid && (issue_rd != AW'(ZERO_REG)) && in_range(issue_rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this storage is a flop array, not an SRAM, so it is cleared on
      // reset; x0 then stays zero because nothing ever writes it.
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   raddr_i;
    logic            raddr_ok;
    logic [XLEN-1:0] rd_stored;
    logic            busy_stored;

    assign raddr_i     = raddr[i*AW +: AW];
    assign raddr_ok    = in_range(raddr_i);
    assign rd_stored   = raddr_ok ? regs_q[raddr_i] : '0;
    assign busy_stored = raddr_ok ? busy_q[raddr_i] : 1'b0;

    rf_bypass_mux #(
      .XLEN  (XLEN),
      .AW    (AW),
      .NWR   (NWR),
      .BYPASS(BYPASS)
    ) u_mux (
      .raddr      (raddr_i),
      .raddr_ok   (raddr_ok),
      .rd_stored  (rd_stored),
      .busy_stored(busy_stored),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .rdata      (rdata[i*XLEN +: XLEN]),
      .rbusy      (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb; a BYPASS=1 and a BYPASS=0
// instance share the same stimulus.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    raddr;
  logic [63:0]   rdata;
  logic [63:0]   rdata_nb;
  logic [1:0]    rbusy;
  logic [1:0]    rbusy_nb;
  logic [1:0]    we;
  logic [9:0]    waddr;
  logic [63:0]   wdata;
  logic          issue_valid;
  logic [4:0]    issue_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  regfile_mp_sb #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave 1 time unit so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p]               = 1'b1;
    waddr[p*AW +: AW]   = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_rd    = a;
  endtask

  function automatic logic [31:0] rdp(input int p);
    return rdata[p*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] rdp_nb(input int p);
    return rdata_nb[p*XLEN +: XLEN];
  endfunction

  initial begin
    raddr = '0;
    idle();

    // 1. Reset and zero register.
    rst = 1'b1;
    wr(0, 5'd9, 32'hFFFF_FFFF);
    issue(5'd9);
    tick();
    rst = 1'b0;
    idle();
    for (int a = 0; a < 32; a++) begin
      rd(0, 5'(a));
      rd(1, 5'(a));
      #1;
      check($sformatf("rst_rdata_x%0d", a), rdp(0), 32'h0);
      check($sformatf("rst_rbusy_x%0d", a), 32'(rbusy[1]), 32'h0);
    end
    wr(0, 5'd0, 32'hDEAD_BEEF);
    issue(5'd0);
    rd(1, 5'd0);
    #1;
    check("x0_bypass", rdp(1), 32'h0);
    tick();
    idle();
    rd(0, 5'd0);
    #1;
    check("x0_stored", rdp(0), 32'h0);
    check("x0_rbusy", 32'(rbusy[0]), 32'h0);

    // 2. Basic write/read, with and without bypass.
    wr(0, 5'd5, 32'h1234_5678);
    rd(1, 5'd5);
    #1;
    check("x5_bypass", rdp(1), 32'h1234_5678);
    check("x5_nobypass_old", rdp_nb(1), 32'h0);
    tick();
    idle();
    rd(0, 5'd5);
    #1;
    check("x5_stored", rdp(0), 32'h1234_5678);
    check("x5_nobypass_new", rdp_nb(0), 32'h1234_5678);

    // 3. Write-port conflict and independent dual writes.
    wr(0, 5'd7, 32'h1);
    wr(1, 5'd7, 32'h2);
    rd(0, 5'd7);
    #1;
    check("x7_conflict_bypass", rdp(0), 32'h2);
    tick();
    idle();
    #1;
    check("x7_conflict_stored", rdp(0), 32'h2);
    wr(0, 5'd8, 32'h0000_0808);
    wr(1, 5'd9, 32'h0000_0909);
    tick();
    idle();
    rd(0, 5'd8);
    rd(1, 5'd9);
    #1;
    check("x8_port0", rdp(0), 32'h0000_0808);
    check("x9_port1", rdp(1), 32'h0000_0909);

    // 4. Scoreboard set, then cleared by writeback with forwarding.
    issue(5'd10);
    rd(0, 5'd10);
    rd(1, 5'd11);
    #1;
    check("x10_busy_before_edge", 32'(rbusy[0]), 32'h0);
    tick();
    idle();
    #1;
    check("x10_busy", 32'(rbusy[0]), 32'h1);
    check("x10_busy_nb", 32'(rbusy_nb[0]), 32'h1);
    check("x11_not_busy", 32'(rbusy[1]), 32'h0);
    wr(1, 5'd10, 32'h0000_00AA);
    #1;
    check("x10_fwd_data", rdp(0), 32'h0000_00AA);
    check("x10_fwd_rbusy", 32'(rbusy[0]), 32'h0);
    check("x10_nb_rbusy", 32'(rbusy_nb[0]), 32'h1);
    check("x10_nb_data", rdp_nb(0), 32'h0);
    tick();
    idle();
    #1;
    check("x10_cleared", 32'(rbusy[0]), 32'h0);
    check("x10_cleared_nb", 32'(rbusy_nb[0]), 32'h0);
    check("x10_stored", rdp(0), 32'h0000_00AA);

    // Set and clear of different registers in one cycle are independent.
    issue(5'd13);
    tick();
    idle();
    issue(5'd12);
    wr(0, 5'd13, 32'h0000_0013);
    tick();
    idle();
    rd(0, 5'd12);
    rd(1, 5'd13);
    #1;
    check("x12_set", 32'(rbusy[0]), 32'h1);
    check("x13_clear", 32'(rbusy[1]), 32'h0);
    check("x13_data", rdp(1), 32'h0000_0013);

    // 5. Set/clear collision on the same register: set wins.
    issue(5'd3);
    tick();
    idle();
    wr(0, 5'd3, 32'h0000_0055);
    issue(5'd3);
    rd(0, 5'd3);
    #1;
    check("x3_collide_fwd", rdp(0), 32'h0000_0055);
    check("x3_collide_fwd_rbusy", 32'(rbusy[0]), 32'h0);
    tick();
    idle();
    #1;
    check("x3_data", rdp(0), 32'h0000_0055);
    check("x3_still_busy", 32'(rbusy[0]), 32'h1);

    // 6. Reset mid-operation overrides a write and an issue.
    wr(0, 5'd4, 32'h0000_0099);
    issue(5'd4);
    tick();
    idle();
    rd(0, 5'd4);
    #1;
    check("x4_pre_data", rdp(0), 32'h0000_0099);
    check("x4_pre_busy", 32'(rbusy[0]), 32'h1);
    rst = 1'b1;
    wr(1, 5'd4, 32'h0000_0077);
    issue(5'd4);
    tick();
    rst = 1'b0;
    idle();
    rd(1, 5'd5);
    #1;
    check("x4_rst_data", rdp(0), 32'h0);
    check("x4_rst_busy", 32'(rbusy[0]), 32'h0);
    check("x5_rst_data", rdp(1), 32'h0);
    rd(1, 5'd12);
    #1;
    check("x12_rst_busy", 32'(rbusy[1]), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
